// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath and its controller:
// mode encodings and the iteration-counter width helper.
package booth_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SR1  = 3'b010;
  localparam logic [2:0] MODE_ASR2 = 3'b011;
  localparam logic [2:0] MODE_SL1  = 3'b100;
  localparam logic [2:0] MODE_ROR1 = 3'b101;
  localparam logic [2:0] MODE_SR2  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  // Counter must hold the value ITER itself, hence ITER+1 states.
  function automatic int calc_cw(input int iter);
    return $clog2(iter + 1);
  endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Saturating iteration counter: clears to zero, counts up to ITER and holds;
// done flags the saturated value.
module booth_iter_counter
  import booth_pkg::*;
#(
  parameter int ITER = 4,
  parameter int CW   = calc_cw(ITER)
) (
  input  logic          clock,
  input  logic          _reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          done
);

  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != ITER_C)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == ITER_C);

endmodule

// File: rtl/booth_mfr_param.sv
// Multifunction register for the Booth datapath: load/clear, radix-2 and
// radix-4 shifts, rotate, a 2-bit shift-out and a built-in iteration counter.
module booth_mfr_param
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITER  = 4,
  parameter int CW    = calc_cw(ITER)
) (
  input  logic             clock,
  input  logic             _reset,
  input  logic [2:0]       mode,
  input  logic [1:0]       shift_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       shift_out,
  output logic [CW-1:0]    count,
  output logic             done
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [1:0]       so_q;
  logic [1:0]       so_d;
  logic             cnt_clear;
  logic             cnt_inc;

  always_comb begin
    q_d       = q_q;
    so_d      = so_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    unique case (mode)
      MODE_HOLD: ;
      MODE_LOAD: begin
        q_d       = d;
        cnt_clear = 1'b1;
      end
      MODE_SR1: begin
        q_d     = {shift_in[0], q_q[WIDTH-1:1]};
        so_d    = {1'b0, q_q[0]};
        cnt_inc = 1'b1;
      end
      MODE_ASR2: begin
        q_d     = {q_q[WIDTH-1], q_q[WIDTH-1], q_q[WIDTH-1:2]};
        so_d    = q_q[1:0];
        cnt_inc = 1'b1;
      end
      MODE_SL1: begin
        q_d     = {q_q[WIDTH-2:0], shift_in[0]};
        so_d    = {1'b0, q_q[WIDTH-1]};
        cnt_inc = 1'b1;
      end
      MODE_ROR1: begin
        q_d     = {q_q[0], q_q[WIDTH-1:1]};
        so_d    = {1'b0, q_q[0]};
        cnt_inc = 1'b1;
      end
      MODE_SR2: begin
        q_d     = {shift_in[1:0], q_q[WIDTH-1:2]};
        so_d    = q_q[1:0];
        cnt_inc = 1'b1;
      end
      MODE_CLR: begin
        q_d       = '0;
        so_d      = '0;
        cnt_clear = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      q_q  <= '0;
      so_q <= '0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end

  booth_iter_counter #(
    .ITER (ITER),
    .CW   (CW)
  ) u_iter_counter (
    .clock  (clock),
    ._reset (_reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .count  (count),
    .done   (done)
  );

  assign q         = q_q;
  assign shift_out = so_q;

endmodule

// File: tb/tb_booth_mfr_param.sv
// Bench for booth_mfr_param (WIDTH=8, ITER=4): directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_booth_mfr_param;

  localparam int W  = 8;
  localparam int IT = 4;
  localparam int CW = 3;

  logic          clock;
  logic          _reset;
  logic [2:0]    mode;
  logic [1:0]    shift_in;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic [1:0]    shift_out;
  logic [CW-1:0] count;
  logic          done;

  int total;
  int bad;

  // reference model state
  int unsigned m_q;
  int unsigned m_so;
  int unsigned m_cnt;

  // packed observation {q, shift_out, count, done}
  logic [W+2+CW:0] obs;
  logic [W+2+CW:0] exp_v;
  logic [W+2+CW:0] exp_q[$];

  booth_mfr_param #(.WIDTH(W), .ITER(IT)) dut (
    .clock     (clock),
    ._reset    (_reset),
    .mode      (mode),
    .shift_in  (shift_in),
    .d         (d),
    .q         (q),
    .shift_out (shift_out),
    .count     (count),
    .done      (done)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign obs = {q, shift_out, count, done};

  function automatic logic [W+2+CW:0] pack(input int unsigned qv, input int unsigned sov,
                                           input int unsigned cv, input bit dv);
    logic [W+2+CW:0] r;
    r = {qv[W-1:0], sov[1:0], cv[CW-1:0], dv};
    return r;
  endfunction

  function automatic logic [W+2+CW:0] model_packed();
    return pack(m_q, m_so, m_cnt, m_cnt == IT);
  endfunction

  // Behavioural model: arithmetic on integers, one call per clock edge.
  task automatic model_step(input logic [2:0] md, input int unsigned dv, input int unsigned si);
    logic signed [W-1:0] s;
    bit shift;
    shift = 1'b1;
    case (md)
      3'd0: shift = 1'b0;
      3'd1: begin m_q = dv & 'hFF; m_cnt = 0; shift = 1'b0; end
      3'd2: begin m_so = m_q % 2; m_q = (m_q / 2) + (si % 2) * 128; end
      3'd3: begin m_so = m_q % 4; s = m_q[W-1:0]; s = s >>> 2; m_q = int'(s) & 'hFF; end
      3'd4: begin m_so = m_q / 128; m_q = ((m_q * 2) + (si % 2)) % 256; end
      3'd5: begin m_so = m_q % 2; m_q = (m_q / 2) + (m_q % 2) * 128; end
      3'd6: begin m_so = m_q % 4; m_q = (m_q / 4) + (si % 4) * 64; end
      default: begin m_q = 0; m_so = 0; m_cnt = 0; shift = 1'b0; end
    endcase
    if (shift && m_cnt < IT) m_cnt = m_cnt + 1;
  endtask

  task automatic model_reset();
    m_q = 0; m_so = 0; m_cnt = 0;
  endtask

  // driver: apply one operation, advance one edge, sample 1 time unit later
  task automatic op(input logic [2:0] md, input logic [W-1:0] dv, input logic [1:0] si);
    @(negedge clock);
    mode = md; d = dv; shift_in = si;
    @(posedge clock);
    #1;
    model_step(md, dv, si);
  endtask

  task automatic test_reset();
    _reset = 1'b0; mode = 3'd0; d = '0; shift_in = '0;
    model_reset();
    #3;
    total++;
    if (obs !== pack(0, 0, 0, 0)) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", obs, pack(0, 0, 0, 0));
    end
    @(negedge clock);
    _reset = 1'b1;
  endtask

  task automatic test_asr2();
    op(3'd1, 8'hB4, 2'b00);
    total++;
    if (obs !== pack('hB4, 0, 0, 0)) begin
      bad++; $display("FAIL load_b4 got=%h exp=%h", obs, pack('hB4, 0, 0, 0));
    end
    op(3'd3, 8'h00, 2'b00);
    total++;
    if (obs !== pack('hED, 0, 1, 0)) begin
      bad++; $display("FAIL asr2_b4 got=%h exp=%h", obs, pack('hED, 0, 1, 0));
    end
  endtask

  task automatic test_shifts();
    op(3'd1, 8'hB5, 2'b00);
    op(3'd2, 8'h00, 2'b01);
    total++;
    if (obs !== pack('hDA, 1, 1, 0)) begin
      bad++; $display("FAIL sr1 got=%h exp=%h", obs, pack('hDA, 1, 1, 0));
    end
    op(3'd1, 8'hB5, 2'b00);
    op(3'd6, 8'h00, 2'b10);
    total++;
    if (obs !== pack('hAD, 1, 1, 0)) begin
      bad++; $display("FAIL sr2 got=%h exp=%h", obs, pack('hAD, 1, 1, 0));
    end
    op(3'd1, 8'hB5, 2'b00);
    op(3'd4, 8'h00, 2'b00);
    total++;
    if (obs !== pack('h6A, 1, 1, 0)) begin
      bad++; $display("FAIL sl1 got=%h exp=%h", obs, pack('h6A, 1, 1, 0));
    end
    op(3'd1, 8'h81, 2'b00);
    op(3'd5, 8'h00, 2'b00);
    total++;
    if (obs !== pack('hC0, 1, 1, 0)) begin
      bad++; $display("FAIL ror1 got=%h exp=%h", obs, pack('hC0, 1, 1, 0));
    end
  endtask

  task automatic test_saturation();
    logic [W+2+CW:0] held;
    int exp_cnt[5] = '{1, 2, 3, 4, 4};
    int exp_qv[5]  = '{'h10, 'h04, 'h01, 'h00, 'h00};
    int exp_so[5]  = '{0, 0, 0, 1, 0};
    op(3'd1, 8'h40, 2'b00);
    for (int i = 0; i < 5; i++) begin
      op(3'd3, 8'h00, 2'b11);
      exp_v = pack(exp_qv[i], exp_so[i], exp_cnt[i], exp_cnt[i] == IT);
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL sat_shift%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    held = exp_v;
    op(3'd0, 8'hFF, 2'b11);
    total++;
    if (obs !== held) begin
      bad++; $display("FAIL hold got=%h exp=%h", obs, held);
    end
    op(3'd1, 8'h12, 2'b00);
    total++;
    if (obs !== pack('h12, 0, 0, 0)) begin
      bad++; $display("FAIL reload got=%h exp=%h", obs, pack('h12, 0, 0, 0));
    end
  endtask

  task automatic test_async_reset();
    op(3'd1, 8'hA7, 2'b00);
    op(3'd2, 8'h00, 2'b01);
    op(3'd6, 8'h00, 2'b10);
    op(3'd3, 8'h00, 2'b00);
    #2;
    _reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== pack(0, 0, 0, 0)) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", obs, pack(0, 0, 0, 0));
    end
    @(negedge clock);
    _reset = 1'b1;
    op(3'd1, 8'h33, 2'b00);
    total++;
    if (obs !== pack('h33, 0, 0, 0)) begin
      bad++; $display("FAIL post_reset_load got=%h exp=%h", obs, pack('h33, 0, 0, 0));
    end
  endtask

  task automatic test_clear();
    op(3'd1, 8'hFF, 2'b00);
    op(3'd2, 8'h00, 2'b01);
    op(3'd2, 8'h00, 2'b01);
    total++;
    if (obs !== pack('hFF, 1, 2, 0)) begin
      bad++; $display("FAIL pre_clear got=%h exp=%h", obs, pack('hFF, 1, 2, 0));
    end
    op(3'd7, 8'hAA, 2'b11);
    total++;
    if (obs !== pack(0, 0, 0, 0)) begin
      bad++; $display("FAIL clear got=%h exp=%h", obs, pack(0, 0, 0, 0));
    end
    // Same clear, now with a reset pulse straddling the clock edge.
    op(3'd1, 8'hFF, 2'b00);
    op(3'd2, 8'h00, 2'b01);
    op(3'd2, 8'h00, 2'b01);
    @(negedge clock);
    mode = 3'd7;
    #3;
    _reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (obs !== pack(0, 0, 0, 0)) begin
        bad++; $display("FAIL clear_rst_pulse%0d got=%h exp=%h", i, obs, pack(0, 0, 0, 0));
      end
    end
    _reset = 1'b1;
    @(posedge clock);
    #1;
    model_step(3'd7, 0, 0);
    total++;
    if (obs !== pack(0, 0, 0, 0)) begin
      bad++; $display("FAIL clear_after_pulse got=%h exp=%h", obs, pack(0, 0, 0, 0));
    end
  endtask

  // Randomized run: expected values are queued by the model and checked in order.
  task automatic test_random();
    logic [2:0]   md;
    logic [W-1:0] dv;
    logic [1:0]   si;
    for (int i = 0; i < 400; i++) begin
      md = 3'($urandom_range(0, 7));
      if (md == 3'd7 && $urandom_range(0, 3) != 0) md = 3'd1;
      dv = W'($urandom);
      si = 2'($urandom_range(0, 3));
      op(md, dv, si);
      exp_q.push_back(model_packed());
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL random%0d mode=%0d got=%h exp=%h", i, md, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    op(3'd1, 8'h5A, 2'b00);
    for (int i = 0; i < 6; i++) begin
      op(3'($urandom_range(2, 6)), 8'h00, 2'($urandom_range(0, 3)));
      exp_v = model_packed();
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL b2b%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    op(3'd1, 8'hC3, 2'b00);
    total++;
    if (obs !== pack('hC3, m_so, 0, 0)) begin
      bad++; $display("FAIL b2b_reload got=%h exp=%h", obs, pack('hC3, m_so, 0, 0));
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_asr2();
    test_shifts();
    test_saturation();
    test_async_reset();
    test_clear();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_mfr_param.md
Name: booth_mfr_param

Overview:
- Parametrised multifunction register for the Booth multiplier datapath (accumulator / multiplier registers).
- Supports:
  - load and clear
  - logical, arithmetic and serial-in shifts by 1 or 2 (radix-2 and radix-4 Booth)
  - shift left and rotate right
- Adds a 2-bit shift-out for radix-4 recoding.
- Adds an iteration counter with a done flag, so the controller FSM needs no separate shift counter.

Parameters:
- WIDTH, 8, register width in bits; legal range 4 or more.
- ITER, 4, number of shift operations after load at which done asserts; legal range 1 or more.
- CW, $clog2(ITER+1), counter width; derived, do not override.

Ports:
- clock  in  1  rising-edge clock
- _reset  in  1  asynchronous, active-low reset
- mode  in  3  operation select; encodings listed under Behaviour
- shift_in  in  2  serial input bits; [0] used by 1-bit shifts, [1:0] by the 2-bit serial shift
- d  in  WIDTH  parallel load data
- q  out  WIDTH  register contents
- shift_out  out  2  bits shifted out on the last shift operation (registered)
- count  out  CW  shifts since last load or clear, saturating at ITER
- done  out  1  high when count == ITER (combinational from count)

Behaviour:
- Reset: reset _reset, asynchronous, active-low; clock clock.
  - _reset low immediately sets q=0, shift_out=0, count=0, done=0, independent of clock and mode.
  - Reset has absolute priority over every mode.
  - Reset asserted mid-sequence aborts the sequence; there is no partial state.
- All other updates occur on the rising edge of clock with _reset high. Latency is one cycle from mode/d/shift_in to q/shift_out/count.
- Mode encodings (q' is next q):
  - 000 HOLD: q, shift_out and count unchanged.
  - 001 LOAD: q'=d; shift_out unchanged; count'=0.
  - 010 SR1: q'={shift_in[0], q[W-1:1]}; shift_out'={1'b0,q[0]}.
  - 011 ASR2: q'={q[W-1],q[W-1],q[W-1:2]}; shift_out'=q[1:0].
  - 100 SL1: q'={q[W-2:0], shift_in[0]}; shift_out'={1'b0,q[W-1]}.
  - 101 ROR1: q'={q[0], q[W-1:1]}; shift_out'={1'b0,q[0]}.
  - 110 SR2: q'={shift_in[1:0], q[W-1:2]}; shift_out'=q[1:0].
  - 111 CLEAR: synchronous; q'=0, shift_out'=0, count'=0.
- Counter rules:
  - Every shift mode (010-110) increments count by 1, saturating at ITER.
  - At saturation, the data still shifts but count holds at ITER and done stays high.
  - LOAD and CLEAR zero the count in the same edge; done drops the cycle after.
  - HOLD never changes count.
- No illegal mode exists; all 8 encodings are defined.
- Width rules:
  - Shifts never widen q.
  - ASR2 replicates the sign bit into the two vacated MSBs.

Decomposition:
- Shared package booth_pkg holds:
  - localparam mode encodings MODE_HOLD, MODE_LOAD, MODE_SR1, MODE_ASR2, MODE_SL1, MODE_ROR1, MODE_SR2, MODE_CLR
  - the ITER/CW derivation helper
- The Booth controller FSM imports the same package.
- One sub-module: booth_iter_counter, a saturating up-counter.
  - Inputs: clear, inc.
  - Outputs: count, done.
  - Parameter: ITER.
- The shift datapath stays in the top module.

Test Plan (WIDTH=8, ITER=4):
- LOAD d=0xB4 then ASR2 -> q=0xB4, count=0; then q=0xED, shift_out=2'b00, count=1, done=0.
- LOAD 0xB5; SR1 shift_in=1 -> q=0xDA, shift_out=2'b01. Reload 0xB5; SR2 shift_in=2'b10 -> q=0xAD, shift_out=2'b01.
- LOAD 0xB5; SL1 shift_in=0 -> q=0x6A, shift_out=2'b01. LOAD 0x81; ROR1 -> q=0xC0, shift_out=2'b01.
- LOAD 0x40, then 5 consecutive ASR2 -> count=1,2,3,4,4; done=1 from 4th shift onward; q after 5th=0x00.
  - HOLD leaves all outputs unchanged.
  - LOAD 0x12 -> count=0, done=0.
- After 3 shifts, drop _reset between clock edges -> q=0, shift_out=0, count=0, done=0 immediately.
  - Release, then LOAD 0x33 -> q=0x33.
- CLEAR from q=0xFF, count=2 -> q=0, shift_out=0, count=0.
  - A simultaneous async reset pulse during the CLEAR cycle -> same zero state, no glitch to a non-zero value.
